// File: rtl/tdm_demux_pkg.sv
// ---------------------------------------------------------------------------
// tdm_demux_pkg
//   Shared definitions for the two-channel TDM demultiplexer.
//   - WIDTH_DEFAULT : default bits per channel word
//   - CNT_W         : width of the per-word bit counter (covers WIDTH up to 16)
//   - state_t       : receiver FSM state encoding
//   Optional feature macro: TDM_DEMUX_PARITY_EN (adds PAR_A / PAR_B states).
// ---------------------------------------------------------------------------
package tdm_demux_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int CNT_W         = 4;

`ifdef TDM_DEMUX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        CH_A,
        CH_B,
        PAR_A,
        PAR_B
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        CH_A,
        CH_B
    } state_t;
`endif

endpackage

// File: rtl/tdm_shift_reg.sv
// ---------------------------------------------------------------------------
// tdm_shift_reg
//   WIDTH-bit serial-in / parallel-out shift register, MSB first, with a
//   synchronous clear that has priority over the shift enable.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset (clears the register)
//     clr   - synchronous clear
//     en    - shift enable; din enters at bit 0, older bits move up
//     din   - serial data in
//     q     - parallel register contents
// ---------------------------------------------------------------------------
module tdm_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/tdm_demux_2ch.sv
// ---------------------------------------------------------------------------
// tdm_demux_2ch
//   Receives a serial TDM frame (sync cycle, channel-A word, channel-B word,
//   MSB first) and presents both words in parallel once the whole frame has
//   arrived. A sync seen mid-frame aborts the current frame and starts a new
//   one immediately.
//   Optional feature macro: TDM_DEMUX_PARITY_EN -- one even-parity bit after
//   each word; a parity mismatch rejects the frame with frame_err.
//   Ports:
//     clk         - system clock, rising edge
//     rst_n       - asynchronous active-low reset
//     sync        - frame-start marker (one cycle high)
//     din         - serial TDM data
//     a_out       - last accepted channel-A word
//     b_out       - last accepted channel-B word
//     frame_valid - one-cycle pulse when a_out/b_out update
//     frame_err   - one-cycle pulse on aborted or rejected frame
//     busy        - high while a frame is being received
// ---------------------------------------------------------------------------
module tdm_demux_2ch #(
    parameter int WIDTH = tdm_demux_pkg::WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             din,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             frame_valid,
    output logic             frame_err,
    output logic             busy
);

    import tdm_demux_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_en;
    logic             b_en;

`ifdef TDM_DEMUX_PARITY_EN
    logic             par_err;
`endif

    // A sync always begins a fresh frame, so it clears both word registers
    // and blocks shifting in that cycle (din is ignored while sync is high).
    assign a_en = (state == CH_A) && !sync;
    assign b_en = (state == CH_B) && !sync;

    tdm_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sync),
        .en    (a_en),
        .din   (din),
        .q     (a_q)
    );

    tdm_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sync),
        .en    (b_en),
        .din   (din),
        .q     (b_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            a_out       <= '0;
            b_out       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err     <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (sync) begin
                // Sync outside IDLE abandons the frame in flight; the new
                // frame is accepted normally either way.
                frame_err <= (state != IDLE);
                state     <= CH_A;
                cnt       <= CNT_LAST;
                busy      <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                par_err   <= 1'b0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end

                    CH_A: begin
                        if (cnt == '0) begin
`ifdef TDM_DEMUX_PARITY_EN
                            state <= PAR_A;
`else
                            state <= CH_B;
                            cnt   <= CNT_LAST;
`endif
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end

                    CH_B: begin
                        if (cnt == '0) begin
`ifdef TDM_DEMUX_PARITY_EN
                            state <= PAR_B;
`else
                            // The last B bit is being sampled on this edge,
                            // so it is merged directly into b_out.
                            state       <= IDLE;
                            busy        <= 1'b0;
                            a_out       <= a_q;
                            b_out       <= {b_q[WIDTH-2:0], din};
                            frame_valid <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end

`ifdef TDM_DEMUX_PARITY_EN
                    PAR_A: begin
                        // Even parity: the parity bit equals the XOR of the word.
                        par_err <= (din != ^a_q);
                        state   <= CH_B;
                        cnt     <= CNT_LAST;
                    end

                    PAR_B: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (par_err || (din != ^b_q)) begin
                            frame_err <= 1'b1;
                        end else begin
                            a_out       <= a_q;
                            b_out       <= b_q;
                            frame_valid <= 1'b1;
                        end
                    end
`endif

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_2ch
//   Directed bench for tdm_demux_2ch (WIDTH=8). Expected words are queued
//   when a frame is driven and compared whenever frame_valid is seen.
//   Honors TDM_DEMUX_PARITY_EN to match the design build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tdm_demux_2ch;

    localparam int W = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int FLEN = 3 + 2 * W;
`else
    localparam int FLEN = 1 + 2 * W;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sync;
    logic         din;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic         frame_valid;
    logic         frame_err;
    logic         busy;

    int total = 0;
    int bad   = 0;

    int cyc_n       = 0;
    int fv_cnt      = 0;
    int fe_cnt      = 0;
    int last_fv_cyc = -1;
    int last_fe_cyc = -1;

    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   model_a = '0;
    logic [W-1:0]   model_b = '0;

    always #5 clk = ~clk;

    tdm_demux_2ch #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync        (sync),
        .din         (din),
        .a_out       (a_out),
        .b_out       (b_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, then observe the outputs of the next cycle.
    task automatic drive(input logic s, input logic d);
        logic [2*W-1:0] e;
        sync = s;
        din  = d;
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        check("fv_fe_exclusive", {31'd0, frame_valid & frame_err}, 32'd0);
        if (frame_valid === 1'b1) begin
            fv_cnt++;
            last_fv_cyc = cyc_n;
            check("sb_nonempty", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_a_out", {24'd0, a_out}, {24'd0, e[2*W-1:W]});
                check("sb_b_out", {24'd0, b_out}, {24'd0, e[W-1:0]});
                model_a = e[2*W-1:W];
                model_b = e[W-1:0];
            end
        end
        if (frame_err === 1'b1) begin
            fe_cnt++;
            last_fe_cyc = cyc_n;
        end
    endtask

    // Data (and parity) bits of a frame after its sync cycle.
    task automatic frame_body(input logic [W-1:0] a, input logic [W-1:0] b, input logic bad_pb);
        logic bits[$];
        for (int i = W - 1; i >= 0; i--) bits.push_back(a[i]);
`ifdef TDM_DEMUX_PARITY_EN
        bits.push_back(^a);
`endif
        for (int i = W - 1; i >= 0; i--) bits.push_back(b[i]);
`ifdef TDM_DEMUX_PARITY_EN
        bits.push_back((^b) ^ bad_pb);
`endif
        foreach (bits[k]) begin
            drive(1'b0, bits[k]);
            if (k < bits.size() - 1) check("busy_mid", {31'd0, busy}, 32'd1);
            else                     check("busy_end", {31'd0, busy}, 32'd0);
        end
        check("fv_at_end", {31'd0, frame_valid}, {31'd0, ~bad_pb});
        check("fe_at_end", {31'd0, frame_err},   {31'd0, bad_pb});
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b);
        int s0;
        exp_q.push_back({a, b});
        s0 = cyc_n;
        drive(1'b1, 1'($urandom_range(0, 1)));
        check("busy_start", {31'd0, busy}, 32'd1);
        frame_body(a, b, 1'b0);
        check("fv_latency", 32'(last_fv_cyc - s0), 32'(FLEN));
    endtask

    initial begin
        int s1;
        int fe0;
        int prev_fv;

        // Reset state
        rst_n = 1'b0;
        sync  = 1'b0;
        din   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a_out", {24'd0, a_out},       32'd0);
        check("rst_b_out", {24'd0, b_out},       32'd0);
        check("rst_fv",    {31'd0, frame_valid}, 32'd0);
        check("rst_fe",    {31'd0, frame_err},   32'd0);
        check("rst_busy",  {31'd0, busy},        32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);

        // Basic frame
        send_frame(8'hA5, 8'h3C);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("basic_fv_count", 32'(fv_cnt), 32'd1);
        check("basic_no_err",   32'(fe_cnt), 32'd0);

        // Abort with sync at cycle 5 of a frame; the restarted frame is accepted
        fe0 = fe_cnt;
        s1  = cyc_n;
        drive(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'(i & 1));
        exp_q.push_back({8'h01, 8'hFF});
        drive(1'b1, 1'b1);
        check("abort_fe",        {31'd0, frame_err}, 32'd1);
        check("abort_fe_cycle",  32'(last_fe_cyc - s1), 32'd6);
        check("abort_a_hold",    {24'd0, a_out}, {24'd0, model_a});
        check("abort_b_hold",    {24'd0, b_out}, {24'd0, model_b});
        check("abort_busy",      {31'd0, busy}, 32'd1);
        frame_body(8'h01, 8'hFF, 1'b0);
        check("abort_fv_cycle",  32'(last_fv_cyc - s1), 32'(FLEN + 5));
        check("abort_one_pulse", 32'(fe_cnt - fe0), 32'd1);
        drive(1'b0, 1'b0);

        // Back-to-back frames
        send_frame(8'h11, 8'h22);
        prev_fv = last_fv_cyc;
        send_frame(8'h33, 8'h44);
        check("b2b_spacing", 32'(last_fv_cyc - prev_fv), 32'(FLEN));

        // Several random back-to-back frames
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 8'($urandom));
        drive(1'b0, 1'b0);

        // Reset in the middle of a frame
        fe0 = fe_cnt;
        drive(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_out", {24'd0, a_out},       32'd0);
        check("mid_rst_b_out", {24'd0, b_out},       32'd0);
        check("mid_rst_fv",    {31'd0, frame_valid}, 32'd0);
        check("mid_rst_fe",    {31'd0, frame_err},   32'd0);
        check("mid_rst_busy",  {31'd0, busy},        32'd0);
        model_a = '0;
        model_b = '0;
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0);
        check("mid_rst_no_err", 32'(fe_cnt - fe0), 32'd0);
        send_frame(8'h5A, 8'hC3);

`ifdef TDM_DEMUX_PARITY_EN
        // Correct parity on A, wrong parity on B: frame rejected
        fe0 = fe_cnt;
        s1  = cyc_n;
        drive(1'b1, 1'b0);
        frame_body(8'hA5, 8'h3C, 1'b1);
        check("par_fe_cycle", 32'(last_fe_cyc - s1), 32'd19);
        check("par_fe_count", 32'(fe_cnt - fe0), 32'd1);
        check("par_a_hold",   {24'd0, a_out}, {24'd0, model_a});
        check("par_b_hold",   {24'd0, b_out}, {24'd0, model_b});
        send_frame(8'h0F, 8'hE1);
`endif

        repeat (3) drive(1'b0, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_2ch.md
TDM_DEMUX_2CH -- requirements
Module: tdm_demux_2ch

Interface
REQ-001 Parameter WIDTH, default 8: bits per channel word; legal range 2..16.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 sync  input  1  frame-start marker, one cycle high, sampled on clk.
REQ-005 din  input  1  serial TDM data, MSB first; channel A word then channel B word.
REQ-006 a_out  output  WIDTH  last accepted channel-A word.
REQ-007 b_out  output  WIDTH  last accepted channel-B word.
REQ-008 frame_valid  output  1  one-cycle pulse when a_out/b_out update.
REQ-009 frame_err  output  1  one-cycle pulse on aborted or rejected frame.
REQ-010 busy  output  1  high while a frame is being received.

Function
REQ-011 States SHALL be IDLE, CH_A, CH_B (plus PAR_A, PAR_B when parity is enabled).
REQ-012 IDLE: sync=1 SHALL move to CH_A with bit counter = WIDTH-1; din is ignored in the sync cycle.
REQ-013 CH_A: din SHALL be shifted in each cycle, MSB first; after WIDTH bits, go to CH_B (or PAR_A).
REQ-014 CH_B: likewise for WIDTH bits; after the last bit, go to IDLE (or PAR_B).
REQ-015 Frame length SHALL be 1+2*WIDTH cycles (3+2*WIDTH with parity), sync cycle included.
REQ-016 a_out and b_out SHALL update together, registered, on the edge after the final frame bit is sampled; frame_valid is high for exactly that cycle.
REQ-017 a_out and b_out SHALL hold their values between accepted frames; partial words are never visible.
REQ-018 busy SHALL be 1 in every state other than IDLE.
REQ-019 sync=1 in any non-IDLE state: abort; frame_err pulses next cycle, outputs held, restart at CH_A bit WIDTH-1 (the new frame is accepted).
REQ-020 sync in the same cycle that frame_valid is high SHALL start a new frame with no dead cycle (back-to-back frames).
REQ-021 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, counter 0, shift registers 0, a_out=0, b_out=0, frame_valid=0, frame_err=0, busy=0.
REQ-023 Reset mid-frame SHALL discard the partial frame with no frame_err pulse; the first sync after release starts a clean frame.

Configuration
REQ-024 Macro TDM_DEMUX_PARITY_EN SHALL, when defined, add one even-parity bit after each word (states PAR_A, PAR_B).
REQ-025 With parity: any mismatch SHALL suppress the output update and pulse frame_err at the frame end, in place of frame_valid.
REQ-026 Without the macro, no parity states, logic or timing SHALL exist; frame length follows REQ-015 without parity.

Structure
REQ-027 Package tdm_demux_pkg SHALL hold the state enum type and the WIDTH default constant.
REQ-028 Sub-module tdm_shift_reg (WIDTH-bit serial-in/parallel-out shift register with clear) SHALL be instantiated once per channel.

Verification (WIDTH=8)
REQ-029 sync at cycle 0, A=0xA5, B=0x3C -> frame_valid at cycle 17, a_out=0xA5, b_out=0x3C, busy high cycles 1-16.
REQ-030 sync again at cycle 5 of a frame -> frame_err at cycle 6, outputs unchanged, a new frame A=0x01, B=0xFF accepted 17 cycles after the second sync.
REQ-031 Two back-to-back frames (0x11/0x22, then 0x33/0x44), the second sync coincident with the first frame_valid -> two frame_valid pulses 17 cycles apart.
REQ-032 rst_n low at cycle 9 of a frame -> all outputs 0 at once, no frame_err; the next frame 0x5A/0xC3 is accepted normally.
REQ-033 TDM_DEMUX_PARITY_EN with a correct parity bit after A=0xA5 (0) and a wrong one after B=0x3C -> frame_err at cycle 19, a_out and b_out hold their prior values.
